maj_net_sequencer: RTL

- Time-multiplexed evaluator for programmable majority-inverter networks over 7 inputs (x0..x6).
- A single shared MAJ3 unit is sequenced through a stored gate list, one gate per clock.
- Any 7-input function in MAJ-network form loads by configuration writes, with no RTL change.
- Sits between a configuration host and a classification/test harness; input-vector and result ports use valid/ready.

---
 rtl/maj_net_pkg.sv | 37 +++
 rtl/maj_net_sequencer_maj3_unit.sv | 24 ++
 rtl/maj_net_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/maj_net_pkg.sv
// Shared types and constants for the majority-network sequencer.
package maj_net_pkg;

    // Default geometry; the top-level parameters take these as defaults.
    localparam int MAX_GATES  = 16;
    localparam int SEL_WIDTH  = 5;
    localparam int CFG_AWIDTH = 5;

    // Layout of the signal space addressed by operand selectors.
    localparam int SIG_CONST0 = 0;
    localparam int SIG_X_BASE = 1;
    localparam int SIG_W_BASE = 8;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    // One gate entry, MSB first: {inv_a, sel_a, inv_b, sel_b, inv_c, sel_c}.
    typedef struct packed {
        logic                 inv_a;
        logic [SEL_WIDTH-1:0] sel_a;
        logic                 inv_b;
        logic [SEL_WIDTH-1:0] sel_b;
        logic                 inv_c;
        logic [SEL_WIDTH-1:0] sel_c;
    } gate_entry_t;

    // Control register, laid out to match the low bits of a config write.
    typedef struct packed {
        logic [CFG_AWIDTH-1:0] num_gates;
        logic                  out_inv;
        logic [SEL_WIDTH-1:0]  out_sel;
    } ctrl_t;

endpackage

// File: rtl/maj_net_sequencer_maj3_unit.sv
// Combinational three-input majority with optional per-input inversion.
module maj3_unit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_inv_a,
    input  logic i_inv_b,
    input  logic i_inv_c,
    output logic o_maj
);

    logic w_a;
    logic w_b;
    logic w_c;

    // Apply operand inversions, then take the majority vote.
    always_comb begin
        w_a   = i_a ^ i_inv_a;
        w_b   = i_b ^ i_inv_b;
        w_c   = i_c ^ i_inv_c;
        o_maj = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
    end

endmodule

// File: rtl/maj_net_sequencer.sv
// Time-multiplexed majority-inverter network evaluator: one shared MAJ3
// unit walks the stored gate list, one gate per clock.
module maj_net_sequencer
    import maj_net_pkg::*;
#(
    parameter int N_GATES = MAX_GATES,
    parameter int SEL_W   = SEL_WIDTH,
    parameter int CFG_AW  = CFG_AWIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [CFG_AW-1:0]      cfg_addr,
    input  logic [3*(SEL_W+1)-1:0] cfg_wdata,
    output logic                   cfg_ready,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6:0]             in_x,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_bit,
    output logic                   busy
);

    localparam int                SIG_N     = 1 << SEL_W;
    localparam int                GIDX_W    = $clog2(N_GATES);
    localparam logic [CFG_AW-1:0] CTRL_ADDR = CFG_AW'(N_GATES);
    localparam logic [CFG_AW-1:0] K_ONE     = CFG_AW'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    gate_entry_t         r_gates [N_GATES];
    ctrl_t               r_ctrl;
    logic [N_GATES-1:0]  r_w;
    logic [6:0]          r_x;
    logic [CFG_AW-1:0]   r_k;

    logic [SIG_N-1:0]    w_sig;
    logic [GIDX_W-1:0]   w_gidx;
    gate_entry_t         w_gate;
    logic                w_maj;
    logic [CFG_AW-1:0]   w_cfg_num;
    logic [CFG_AW-1:0]   w_num_sat;

    // Assemble the flat signal space; unused high selectors read as 0.
    always_comb begin
        w_sig                          = '0;
        w_sig[SIG_X_BASE +: 7]         = r_x;
        w_sig[SIG_W_BASE +: N_GATES]   = r_w;
        w_sig[SIG_CONST0]              = 1'b0;
    end

    // Fetch the current gate and saturate a requested gate count.
    always_comb begin
        w_gidx    = r_k[GIDX_W-1:0];
        w_gate    = r_gates[w_gidx];
        w_cfg_num = cfg_wdata[SEL_W+1 +: CFG_AW];
        w_num_sat = (w_cfg_num > CTRL_ADDR) ? CTRL_ADDR : w_cfg_num;
    end

    maj3_unit u_maj3 (
        .i_a     (w_sig[w_gate.sel_a]),
        .i_b     (w_sig[w_gate.sel_b]),
        .i_c     (w_sig[w_gate.sel_c]),
        .i_inv_a (w_gate.inv_a),
        .i_inv_b (w_gate.inv_b),
        .i_inv_c (w_gate.inv_c),
        .o_maj   (w_maj)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        cfg_ready   = 1'b0;
        out_valid   = 1'b0;
        out_bit     = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (in_valid) begin
                    w_state_nxt = (r_ctrl.num_gates != '0) ? EVAL : DONE;
                end
            end
            EVAL: begin
                if (r_k == r_ctrl.num_gates - K_ONE) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_bit   = w_sig[r_ctrl.out_sel] ^ r_ctrl.out_inv;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Configuration storage, input latch and gate-result register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_GATES; i++) begin
                r_gates[i] <= '0;
            end
            r_ctrl <= '0;
            r_w    <= '0;
            r_x    <= '0;
            r_k    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_we) begin
                        if (cfg_addr < CTRL_ADDR) begin
                            r_gates[cfg_addr[GIDX_W-1:0]] <= gate_entry_t'(cfg_wdata);
                        end else if (cfg_addr == CTRL_ADDR) begin
                            r_ctrl.num_gates <= w_num_sat;
                            r_ctrl.out_inv   <= cfg_wdata[SEL_W];
                            r_ctrl.out_sel   <= cfg_wdata[SEL_W-1:0];
                        end
                    end
                    if (in_valid) begin
                        r_x <= in_x;
                        r_w <= '0;
                        r_k <= '0;
                    end
                end
                EVAL: begin
                    r_w[w_gidx] <= w_maj;
                    r_k         <= r_k + K_ONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
